// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit holding the HI/LO registers (mult/multu/div/divu/mthi/mtlo).
// Latency: MULT_CYCLES or DIV_CYCLES busy cycles, with HI/LO visible the cycle after busy falls; mthi/mtlo take one edge.
// Backpressure: stall_req_E holds later MDU ops in D from the start cycle to the end of the busy window.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_V1,
    input  logic [31:0] E_V2,
    input  logic [3:0]  MDUOp_E,
    output logic [31:0] HI_E,
    output logic [31:0] LO_E,
    output logic        busy_E,
    output logic        stall_req_E
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    state_t      state;
    logic [3:0]  cnt;
    logic [63:0] pend;
    logic        pend_wr;

    logic        is_md_op;
    logic        start;
    logic [63:0] smul;
    logic [63:0] umul;
    logic [31:0] a_mag, b_mag, dvd, dvs, uq, ur;
    logic [31:0] q_res, r_res;
    logic [63:0] res;
    logic        res_wr;

    assign is_md_op    = (MDUOp_E >= OP_MULT) && (MDUOp_E <= OP_DIVU);
    assign start       = (state == IDLE) && is_md_op;
    assign stall_req_E = busy_E | start;

    assign smul = $signed({{32{E_V1[31]}}, E_V1}) * $signed({{32{E_V2[31]}}, E_V2});
    assign umul = {32'd0, E_V1} * {32'd0, E_V2};

    // One unsigned divider on magnitudes; signs are restored afterwards so that
    // 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
    assign a_mag = E_V1[31] ? (~E_V1 + 32'd1) : E_V1;
    assign b_mag = E_V2[31] ? (~E_V2 + 32'd1) : E_V2;
    assign dvd   = (MDUOp_E == OP_DIV) ? a_mag : E_V1;
    assign dvs   = (E_V2 == 32'd0) ? 32'd1 : ((MDUOp_E == OP_DIV) ? b_mag : E_V2);
    assign uq    = dvd / dvs;
    assign ur    = dvd % dvs;
    assign q_res = (E_V1[31] ^ E_V2[31]) ? (~uq + 32'd1) : uq;
    assign r_res = E_V1[31] ? (~ur + 32'd1) : ur;

    always_comb begin
        res    = 64'd0;
        res_wr = 1'b1;
        case (MDUOp_E)
            OP_MULT:  res = smul;
            OP_MULTU: res = umul;
            OP_DIV: begin
                res    = {r_res, q_res};
                res_wr = (E_V2 != 32'd0);
            end
            OP_DIVU: begin
                res    = {ur, uq};
                res_wr = (E_V2 != 32'd0);
            end
            default: res = 64'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            pend    <= 64'd0;
            pend_wr <= 1'b0;
            busy_E  <= 1'b0;
            HI_E    <= 32'd0;
            LO_E    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pend    <= res;
                        pend_wr <= res_wr;
                        cnt     <= ((MDUOp_E == OP_MULT) || (MDUOp_E == OP_MULTU)) ?
                                   4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                        busy_E  <= 1'b1;
                        state   <= RUN;
                    end else if (MDUOp_E == OP_MTHI) begin
                        HI_E <= E_V1;
                    end else if (MDUOp_E == OP_MTLO) begin
                        LO_E <= E_V1;
                    end
                end
                RUN: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        if (pend_wr) begin
                            HI_E <= pend[63:32];
                            LO_E <= pend[31:0];
                        end
                        busy_E <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Table-driven and randomized checks of e_mdu against an arithmetic reference model.
module tb_e_mdu;

    logic        clk;
    logic        reset;
    logic [31:0] E_V1, E_V2;
    logic [3:0]  MDUOp_E;
    logic [31:0] HI_E, LO_E;
    logic        busy_E, stall_req_E;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] ehi, elo;

    e_mdu dut (
        .clk(clk), .reset(reset), .E_V1(E_V1), .E_V2(E_V2), .MDUOp_E(MDUOp_E),
        .HI_E(HI_E), .LO_E(LO_E), .busy_E(busy_E), .stall_req_E(stall_req_E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        int          busy;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference model: plain signed/unsigned 64-bit arithmetic.
    task automatic model(input logic [3:0] op, input logic [31:0] v1, input logic [31:0] v2,
                         output int nbusy);
        longint          a, b, q, r, p;
        longint unsigned up;
        nbusy = 0;
        a = longint'($signed(v1));
        b = longint'($signed(v2));
        case (op)
            4'd1: begin p = a * b; ehi = p[63:32]; elo = p[31:0]; nbusy = 5; end
            4'd2: begin up = 64'(v1) * 64'(v2); ehi = up[63:32]; elo = up[31:0]; nbusy = 5; end
            4'd3: begin
                nbusy = 10;
                if (v2 != 0) begin q = a / b; r = a % b; elo = q[31:0]; ehi = r[31:0]; end
            end
            4'd4: begin
                nbusy = 10;
                if (v2 != 0) begin elo = v1 / v2; ehi = v1 % v2; end
            end
            4'd5: ehi = v1;
            4'd6: elo = v1;
            default: ;
        endcase
    endtask

    // Called at a negedge; returns at the negedge of the first cycle after busy falls.
    task automatic run_op(input logic [3:0] op, input logic [31:0] v1, input logic [31:0] v2,
                          input string tag, output int nbusy);
        logic stall_ok;
        MDUOp_E = op; E_V1 = v1; E_V2 = v2;
        #1;
        chk({tag, " stall_start"}, 32'(stall_req_E), 32'((op >= 1 && op <= 4) ? 1 : 0));
        @(negedge clk);
        MDUOp_E = 4'd0;
        nbusy    = 0;
        stall_ok = 1'b1;
        while (busy_E === 1'b1 && nbusy < 40) begin
            nbusy++;
            if (stall_req_E !== 1'b1) stall_ok = 1'b0;
            @(negedge clk);
        end
        chk({tag, " stall_busy"}, 32'(stall_ok), 32'd1);
    endtask

    vec_t vecs[9];

    initial begin
        int nb, eb;
        vecs[0] = '{4'd1, 32'hFFFFFFFF, 32'd2,          5,  32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'd2,          5,  32'h00000001, 32'hFFFFFFFE};
        vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,          10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{4'd4, 32'd100,      32'd7,          10, 32'd2,        32'd14};
        vecs[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF,   10, 32'd0,        32'h80000000};
        vecs[5] = '{4'd6, 32'h0000ABCD, 32'd0,          0,  32'd0,        32'h0000ABCD};
        vecs[6] = '{4'd5, 32'h00000011, 32'd0,          0,  32'h11,       32'h0000ABCD};
        vecs[7] = '{4'd6, 32'h00000022, 32'd0,          0,  32'h11,       32'h22};
        vecs[8] = '{4'd3, 32'h12345678, 32'd0,          10, 32'h11,       32'h22};

        reset = 1'b0; MDUOp_E = 4'd0; E_V1 = 32'd0; E_V2 = 32'd0;
        #12;
        chk("reset HI", HI_E, 32'd0);
        chk("reset LO", LO_E, 32'd0);
        chk("reset busy", 32'(busy_E), 32'd0);
        chk("reset stall", 32'(stall_req_E), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].v1, vecs[i].v2, $sformatf("vec%0d", i), nb);
            chk($sformatf("vec%0d busy_cycles", i), 32'(nb), 32'(vecs[i].busy));
            chk($sformatf("vec%0d HI", i), HI_E, vecs[i].hi);
            chk($sformatf("vec%0d LO", i), LO_E, vecs[i].lo);
        end
        ehi = HI_E; elo = LO_E;
        ehi = 32'h11; elo = 32'h22;

        // mthi arriving during a mult busy window must be ignored.
        MDUOp_E = 4'd1; E_V1 = 32'h00010000; E_V2 = 32'h00030000;
        @(negedge clk);
        MDUOp_E = 4'd5; E_V1 = 32'hDEADBEEF;
        repeat (2) @(negedge clk);
        MDUOp_E = 4'd0;
        repeat (4) @(negedge clk);
        chk("mthi_in_busy busy_fell", 32'(busy_E), 32'd0);
        chk("mthi_in_busy HI", HI_E, 32'h00000003);
        chk("mthi_in_busy LO", LO_E, 32'h00000000);

        // Reset asserted in busy cycle 4 of a divide.
        MDUOp_E = 4'd4; E_V1 = 32'd1000; E_V2 = 32'd3;
        @(negedge clk);
        MDUOp_E = 4'd0;
        repeat (3) @(negedge clk);
        chk("pre_reset busy", 32'(busy_E), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("midop_reset busy", 32'(busy_E), 32'd0);
        chk("midop_reset HI", HI_E, 32'd0);
        chk("midop_reset LO", LO_E, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset idle", 32'(busy_E), 32'd0);
        run_op(4'd1, 32'hFFFFFFFD, 32'd7, "post_reset_mult", nb);
        chk("post_reset_mult busy_cycles", 32'(nb), 32'd5);
        chk("post_reset_mult HI", HI_E, 32'hFFFFFFFF);
        chk("post_reset_mult LO", LO_E, 32'hFFFFFFEB);
        ehi = 32'hFFFFFFFF; elo = 32'hFFFFFFEB;

        // Back-to-back: multu presented in the first idle cycle after busy falls.
        run_op(4'd2, 32'h00000010, 32'h00000010, "b2b_multu", nb);
        chk("b2b_multu busy_cycles", 32'(nb), 32'd5);
        chk("b2b_multu LO", LO_E, 32'h100);
        ehi = 32'd0; elo = 32'h100;

        // Randomized ops against the reference model.
        for (int k = 0; k < 40; k++) begin
            logic [3:0]  op;
            logic [31:0] v1, v2;
            op = 4'($urandom_range(0, 8));
            v1 = $urandom;
            v2 = ($urandom_range(0, 6) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) v2 = 32'($urandom_range(1, 20));
            model(op, v1, v2, eb);
            run_op(op, v1, v2, $sformatf("rnd%0d", k), nb);
            chk($sformatf("rnd%0d op%0d busy_cycles", k, op), 32'(nb), 32'(eb));
            chk($sformatf("rnd%0d op%0d HI", k, op), HI_E, ehi);
            chk($sformatf("rnd%0d op%0d LO", k, op), LO_E, elo);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
